// File: rtl/sq_sequencer_if.sv
// Handshake and operand bus between the squaring controller and its user.
// The master drives start/op_in; the slave (sq_sequencer) drives the rest.
interface sq_sequencer_if #(
    parameter int NUM_LIMBS = 129,
    parameter int LIMB_W    = 17
);
    logic                              start;
    logic [NUM_LIMBS-1:0][LIMB_W-1:0]  op_in;
    logic [NUM_LIMBS-1:0][LIMB_W-1:0]  curr_op;
    logic [4:0]                        SQ_STATE;
    logic                              busy;
    logic                              prod_valid;
    logic [2:0]                        prod_step;
    logic                              done;

    modport master (
        output start, op_in,
        input  curr_op, SQ_STATE, busy, prod_valid, prod_step, done
    );

    modport slave (
        input  start, op_in,
        output curr_op, SQ_STATE, busy, prod_valid, prod_step, done
    );
endinterface

// File: rtl/sq_sequencer.sv
// Squaring control stage: latches the operand on an accepted start, steps
// SQ_STATE through phases 1..5, and tracks each phase through the
// MUL_LAT-deep multiplier array so products arrive tagged with their phase.
module sq_sequencer #(
    parameter int NUM_LIMBS = 129,
    parameter int LIMB_W    = 17,
    parameter int MUL_LAT   = 3     // legal range 1..8
) (
    input  logic          clk,
    input  logic          reset,
    sq_sequencer_if.slave bus
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    localparam logic [4:0] LAST_PHASE = 5'd5;

    logic [1:0]                       state_q, state_d;
    logic [4:0]                       sq_state_q, sq_state_d;
    logic                             busy_q, busy_d;
    logic [NUM_LIMBS-1:0][LIMB_W-1:0] curr_op_q, curr_op_d;

    // Tag pipe mirrors the multiplier latency; 'last' marks the phase-5 slot
    // so done is a plain register output rather than a decode of the tail.
    logic [MUL_LAT-1:0]               tag_vld_q;
    logic [MUL_LAT-1:0]               tag_last_q;
    logic [MUL_LAT-1:0][2:0]          tag_step_q;

    logic                             done_q;
    assign done_q = tag_last_q[MUL_LAT-1];

    // Next-state decode for the IDLE -> ISSUE -> DRAIN sequence.
    always_comb begin
        // NOTE: every target gets a default first so no path leaves it unassigned, which would infer a latch.
        state_d    = state_q;
        sq_state_d = sq_state_q;
        busy_d     = busy_q;
        curr_op_d  = curr_op_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    curr_op_d  = bus.op_in;
                    sq_state_d = 5'd1;
                    busy_d     = 1'b1;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                if (sq_state_q == LAST_PHASE) begin
                    sq_state_d = 5'd0;
                    state_d    = DRAIN;
                end else begin
                    sq_state_d = sq_state_q + 5'd1;
                end
            end
            DRAIN: begin
                // Release one edge after the phase-5 products are presented.
                if (done_q) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d    = IDLE;
                sq_state_d = 5'd0;
                busy_d     = 1'b0;
            end
        endcase
    end

    // Control state and latched operand registers.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: the wide operand register is reset too, because curr_op must read zero after reset.
        if (reset) begin
            state_q    <= IDLE;
            sq_state_q <= 5'd0;
            busy_q     <= 1'b0;
            curr_op_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q    <= state_d;
            sq_state_q <= sq_state_d;
            busy_q     <= busy_d;
            curr_op_q  <= curr_op_d;
        end
    end

    // Shift each issued phase tag through the multiplier-latency pipe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tag_vld_q  <= '0;
            tag_last_q <= '0;
            tag_step_q <= '0;
        end else begin
            tag_vld_q[0]  <= (sq_state_q != 5'd0);
            tag_last_q[0] <= (sq_state_q == LAST_PHASE);
            tag_step_q[0] <= sq_state_q[2:0];
            for (int i = 1; i < MUL_LAT; i++) begin
                tag_vld_q[i]  <= tag_vld_q[i-1];
                tag_last_q[i] <= tag_last_q[i-1];
                tag_step_q[i] <= tag_step_q[i-1];
            end
        end
    end

    assign bus.curr_op    = curr_op_q;
    assign bus.SQ_STATE   = sq_state_q;
    assign bus.busy       = busy_q;
    assign bus.prod_valid = tag_vld_q[MUL_LAT-1];
    assign bus.prod_step  = tag_step_q[MUL_LAT-1];
    assign bus.done       = done_q;

endmodule

// File: tb/tb_sq_sequencer.sv
// Directed bench for sq_sequencer: one instance at MUL_LAT=3, one at MUL_LAT=1.
// Inputs are driven and outputs sampled on the falling edge; after driving
// start at a falling edge, the k-th following falling edge lies in cycle T+k.
module tb_sq_sequencer;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    sq_sequencer_if #(.NUM_LIMBS(129), .LIMB_W(17)) if3 ();
    sq_sequencer_if #(.NUM_LIMBS(129), .LIMB_W(17)) if1 ();

    sq_sequencer #(.NUM_LIMBS(129), .LIMB_W(17), .MUL_LAT(3)) u_lat3 (
        .clk   (clk),
        .reset (reset),
        .bus   (if3.slave)
    );

    sq_sequencer #(.NUM_LIMBS(129), .LIMB_W(17), .MUL_LAT(1)) u_lat1 (
        .clk   (clk),
        .reset (reset),
        .bus   (if1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        if3.start = 1'b0;
        if3.op_in = '0;
        if1.start = 1'b0;
        if1.op_in = '0;

        // Reset state
        #2;
        check("rst_curr_op0", 32'(if3.curr_op[0]), 32'h0);
        check("rst_sq_state", 32'(if3.SQ_STATE), 0);
        check("rst_busy", 32'(if3.busy), 0);
        check("rst_prod_valid", 32'(if3.prod_valid), 0);
        check("rst_prod_step", 32'(if3.prod_step), 0);
        check("rst_done", 32'(if3.done), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Single op, MUL_LAT=3, with operand changing while busy
        if3.op_in[0]   = 17'h1ABCD;
        if3.op_in[128] = 17'h00001;
        if3.start      = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (k == 1) begin
                if3.start      = 1'b0;
                if3.op_in[128] = 17'h1FFFF;
                check("single_curr_op0", 32'(if3.curr_op[0]), 32'h1ABCD);
            end
            check($sformatf("single_sq_state_k%0d", k), 32'(if3.SQ_STATE), (k <= 5) ? k : 0);
            check($sformatf("single_prod_valid_k%0d", k), 32'(if3.prod_valid), (k >= 4 && k <= 8) ? 1 : 0);
            check($sformatf("single_prod_step_k%0d", k), 32'(if3.prod_step), (k >= 4 && k <= 8) ? k - 3 : 0);
            check($sformatf("single_done_k%0d", k), 32'(if3.done), (k == 8) ? 1 : 0);
            check($sformatf("single_busy_k%0d", k), 32'(if3.busy), (k <= 8) ? 1 : 0);
            check($sformatf("stable_curr_op128_k%0d", k), 32'(if3.curr_op[128]), 32'h00001);
        end

        // Idle hold: 20 cycles with start low
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            check($sformatf("idle_sq_state_k%0d", k), 32'(if3.SQ_STATE), 0);
            check($sformatf("idle_prod_valid_k%0d", k), 32'(if3.prod_valid), 0);
            check($sformatf("idle_curr_op0_k%0d", k), 32'(if3.curr_op[0]), 32'h1ABCD);
        end

        // start held high: second op accepted at the edge ending T+9
        if3.op_in[0] = 17'h00111;
        if3.start    = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            check($sformatf("cont_sq_state_k%0d", k), 32'(if3.SQ_STATE),
                  (k <= 5) ? k : ((k >= 10) ? k - 9 : 0));
            check($sformatf("cont_prod_valid_k%0d", k), 32'(if3.prod_valid), (k >= 4 && k <= 8) ? 1 : 0);
            check($sformatf("cont_busy_k%0d", k), 32'(if3.busy), (k == 9) ? 0 : 1);
            check($sformatf("cont_done_k%0d", k), 32'(if3.done), (k == 8) ? 1 : 0);
        end
        if3.start = 1'b0;
        // Second op began at T2 = T+9; we are in cycle T2+3. Its products run T2+4..T2+8.
        for (int k = 4; k <= 9; k++) begin
            @(negedge clk);
            check($sformatf("cont2_prod_step_k%0d", k), 32'(if3.prod_step), (k <= 8) ? k - 3 : 0);
            check($sformatf("cont2_done_k%0d", k), 32'(if3.done), (k == 8) ? 1 : 0);
        end

        // Reset asserted asynchronously mid-cycle T+3
        if3.start = 1'b1;
        @(negedge clk);
        if3.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rstop_sq_state_before", 32'(if3.SQ_STATE), 3);
        #1 reset = 1'b1;
        #1;
        check("rstop_sq_state", 32'(if3.SQ_STATE), 0);
        check("rstop_busy", 32'(if3.busy), 0);
        check("rstop_prod_valid", 32'(if3.prod_valid), 0);
        check("rstop_prod_step", 32'(if3.prod_step), 0);
        check("rstop_done", 32'(if3.done), 0);
        check("rstop_curr_op0", 32'(if3.curr_op[0]), 0);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            check($sformatf("post_rst_prod_valid_k%0d", k), 32'(if3.prod_valid), 0);
            check($sformatf("post_rst_done_k%0d", k), 32'(if3.done), 0);
            check($sformatf("post_rst_busy_k%0d", k), 32'(if3.busy), 0);
        end

        // Short pipeline, MUL_LAT=1
        if1.op_in[0] = 17'h0BEEF;
        if1.start    = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) begin
                if1.start = 1'b0;
                check("short_curr_op0", 32'(if1.curr_op[0]), 32'h0BEEF);
            end
            check($sformatf("short_sq_state_k%0d", k), 32'(if1.SQ_STATE), (k <= 5) ? k : 0);
            check($sformatf("short_prod_valid_k%0d", k), 32'(if1.prod_valid), (k >= 2 && k <= 6) ? 1 : 0);
            check($sformatf("short_prod_step_k%0d", k), 32'(if1.prod_step), (k >= 2 && k <= 6) ? k - 1 : 0);
            check($sformatf("short_done_k%0d", k), 32'(if1.done), (k == 6) ? 1 : 0);
            check($sformatf("short_busy_k%0d", k), 32'(if1.busy), (k <= 6) ? 1 : 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
